// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the instruction-memory bus, the redirect input and the
//               instruction-register handshake of the fetch stage.
//               master : the fetch unit (drives mem_req/mem_addr, ir_*)
//               slave  : the environment (memory, branch unit, decoder)
//               Signals:
//                 fetch_en    - permits new requests
//                 mem_req     - read request        mem_addr   - request address
//                 mem_gnt     - request accepted    mem_rvalid - read data valid
//                 mem_rdata   - read data
//                 redirect    - flush pulse         redirect_pc- restart address
//                 ir_valid    - head valid          ir_ready   - decoder accepts
//                 ir_data     - head instruction    ir_pc      - head address
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_en;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;

    modport master (
        input  fetch_en,
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        input  redirect,
        input  redirect_pc,
        output ir_valid,
        input  ir_ready,
        output ir_data,
        output ir_pc
    );

    modport slave (
        output fetch_en,
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        output redirect,
        output redirect_pc,
        input  ir_valid,
        output ir_ready,
        input  ir_data,
        input  ir_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Issues sequential fetch requests,
//               keeps at most DEPTH requests-or-buffered-words in the system
//               (credit scheme), and queues returned words with their PC in a
//               prefetch FIFO. A one-cycle redirect flushes the FIFO and
//               discards responses of requests issued before it.
//               Ports:
//                 clk   - clock, all state updates on posedge
//                 rst_n - asynchronous active-low reset
//                 bus   - fetch_unit_if.master (memory bus, redirect, IR side)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0004)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fetch_unit_if.master     bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;     // holds 0..DEPTH
    localparam int SUM_W = CNT_W + 1;     // holds count + infl without overflow

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  c_depth   = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0]  c_credits = SUM_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] r_fetch_pc;   // next address to request
    logic [ADDR_W-1:0] r_rsp_pc;     // address of the next accepted response
    logic [CNT_W-1:0]  r_count;      // FIFO occupancy
    logic [CNT_W-1:0]  r_infl;       // granted, not yet returned
    logic [CNT_W-1:0]  r_drop_cnt;   // stale responses still to be discarded
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic w_credit_ok;
    logic w_mem_req;
    logic w_grant;
    logic w_rsp;
    logic w_discard;
    logic w_push;
    logic w_ir_valid;
    logic w_pop;

    // Buffered words and outstanding requests share the same DEPTH credits,
    // so every response is guaranteed a FIFO slot on arrival.
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_infl}) < c_credits;

    // rst_n gates the request so it is low for the whole reset interval,
    // not just after the first clock edge.
    assign w_mem_req  = rst_n & bus.fetch_en & ~bus.redirect & w_credit_ok;
    assign w_grant    = w_mem_req & bus.mem_gnt;
    assign w_rsp      = bus.mem_rvalid;

    // A response is stale if it belongs to a request issued before a previous
    // redirect (drop_cnt) or if it lands in the redirect cycle itself.
    assign w_discard  = w_rsp & ((r_drop_cnt != '0) | bus.redirect);
    assign w_push     = w_rsp & ~w_discard;

    assign w_ir_valid = (r_count != '0);
    assign w_pop      = w_ir_valid & bus.ir_ready & ~bus.redirect;

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_count    <= '0;
            r_infl     <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            // No grant is possible during redirect, so this single update
            // covers both the normal and the redirect cycle.
            r_infl <= r_infl + CNT_W'(w_grant) - CNT_W'(w_rsp);

            if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_pc;
                r_rsp_pc   <= bus.redirect_pc;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                // Every request still outstanding after this cycle is stale;
                // the one returning now is already discarded above.
                r_drop_cnt <= r_infl - CNT_W'(w_rsp);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + c_pc_step;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + c_pc_step;
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
                if (w_rsp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.mem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = r_fetch_pc;
    assign bus.ir_valid = w_ir_valid;
    assign bus.ir_data  = w_ir_valid ? r_fifo_data[r_rd_ptr] : '0;
    // When empty, ir_pc shows the address the next instruction will carry
    // (RESET_PC straight out of reset).
    assign bus.ir_pc    = w_ir_valid ? r_fifo_pc[r_rd_ptr] : r_rsp_pc;

    // ------------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == c_depth)));
    a_rsp_expected : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rsp && (r_infl == '0)));
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage sitting between instruction memory and the instruction register/decoder. It generates sequential fetch addresses, keeps up to DEPTH requests outstanding under a credit scheme, and buffers returned words with their PC in a prefetch FIFO. A one-cycle redirect (branch/exception) flushes the FIFO and silently discards stale in-flight responses.

## Interface
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction word width
- DEPTH, 4, FIFO entries and max outstanding credits; power of two, >= 2
- PC_STEP, 4, address increment per request
- RESET_PC, 32'h00000004, first fetch address after reset
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new requests; in-flight ones always complete
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  request address
- mem_gnt  in  1  request accepted when mem_req && mem_gnt
- mem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after grant
- mem_rdata  in  DATA_W  read data
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- ir_valid  out  1  FIFO head valid
- ir_ready  in  1  decoder accepts head when ir_valid && ir_ready
- ir_data  out  DATA_W  head instruction; 0 when ir_valid = 0
- ir_pc  out  ADDR_W  address of head instruction

## Operation
- State: fetch_pc, rsp_pc, FIFO (data+pc, count 0..DEPTH), infl (accepted, not yet returned, 0..DEPTH), drop_cnt (0..DEPTH).
- mem_req = fetch_en && !redirect && (count + infl < DEPTH), combinational; mem_addr = fetch_pc.
- Grant: fetch_pc += PC_STEP (mod 2^ADDR_W, wraps silently), infl += 1.
- Response: infl -= 1. If drop_cnt > 0 or redirect this cycle: discarded, drop_cnt -= 1 when nonzero. Else push {mem_rdata, rsp_pc}, rsp_pc += PC_STEP.
- Pop on ir_valid && ir_ready. Push and pop same cycle: count unchanged. Credit rule guarantees no push when full; a response arriving with count = DEPTH is a protocol error (assertion only).
- Redirect cycle: FIFO emptied (pop ignored), fetch_pc <= redirect_pc, rsp_pc <= redirect_pc, drop_cnt <= infl minus 1 if a response arrives this cycle (that response is itself discarded). No grant possible (mem_req low).
- Dropped in-flight requests keep consuming credits until returned.
- mem_req may deassert before grant only via redirect or fetch_en low; otherwise mem_addr held stable until granted.
- Reset (any time, including mid-burst): mem_req 0 while rst_n low, mem_addr = fetch_pc = rsp_pc = RESET_PC, ir_valid 0, ir_data 0, ir_pc RESET_PC, count/infl/drop_cnt 0. Memory is reset alongside; no responses expected after release.

## Timing
- First request in cycle after rst_n rises (if fetch_en high).
- Response accepted at edge t -> ir_valid at t (registered push), visible cycle after rvalid.
- Sustained 1 instruction/cycle when memory latency + 1 <= DEPTH and ir_ready held high.
- Redirect at cycle r: ir_valid low from r+1; first new request in r+1; first new instruction earliest r+3 with 1-cycle memory.
- fetch_en low: mem_req low same cycle (combinational); FIFO still fills from in-flight responses.

## Test plan
- Reset, fetch_en=1, mem_gnt=1, 1-cycle memory returning addr as data, ir_ready=1 -> ir_pc/ir_data = 0x4, 0x8, 0xC... one per cycle after 2-cycle startup.
- ir_ready=0, DEPTH=4 -> exactly 4 grants, mem_req drops, ir_valid stays with ir_pc=0x4; raise ir_ready -> drains 0x4..0x10, fetching resumes at 0x14.
- 3-cycle memory latency, 3 requests in flight, redirect to 0x100 -> all 3 responses discarded, next ir_pc=0x100, data from address 0x100.
- Redirect in same cycle as a response and a pop -> response dropped, FIFO count 0 next cycle, drop_cnt = infl-1.
- mem_gnt held low 5 cycles -> mem_req stays high, mem_addr stable at 0x4; fetch_en low in middle -> mem_req low immediately, in-flight response still delivered.
- rst_n asserted with 2 outstanding and full FIFO -> all outputs at reset values asynchronously; fetch_pc=ADDR max-3, PC_STEP=4 -> wraps to 0x0 without error.
